// File: rtl/softmax_argmax.sv
// -----------------------------------------------------------------------------
// softmax_argmax
//
// Classification stage after the 10-way softmax. When in_valid rises, it
// captures the packed IEEE-754 single-precision probability vector. It then
// scans the vector one element per clock. It reports the index and value of
// the largest element and holds that result until in_valid drops.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (aborts any scan)
//   in_valid   level request, mirrors the softmax ack
//   inputs     packed elements, element i at [DATA_WIDTH*i +: DATA_WIDTH]
//   busy       high while scanning
//   done       high while the result is presented
//   class_idx  index of the maximum element
//   max_value  value of the maximum element
//   nan_flag   at least one element was NaN (only when NaN checking is built)
//
// Build option:
//   ARGMAX_NAN_CHECK_EN - when defined, NaN elements are skipped and nan_flag
//                         reports them. When undefined, NaNs are ordered like
//                         any other bit pattern and nan_flag is tied low.
// -----------------------------------------------------------------------------
module softmax_argmax #(
    parameter int DATA_WIDTH = 32,
    parameter int INPUT_NUM  = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    input  logic [DATA_WIDTH*INPUT_NUM-1:0] inputs,
    output logic                            busy,
    output logic                            done,
    output logic [IDX_WIDTH-1:0]            class_idx,
    output logic [DATA_WIDTH-1:0]           max_value,
    output logic                            nan_flag
);

    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(INPUT_NUM - 1);
    localparam logic [DATA_WIDTH-1:0] QNAN     = 32'h7FC0_0000;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                  stateReg, stateNext;

    logic [DATA_WIDTH-1:0]   elemIn    [INPUT_NUM];
    logic [DATA_WIDTH-1:0]   bufferReg [INPUT_NUM];

    logic [DATA_WIDTH-1:0]   bestReg;
    logic [IDX_WIDTH-1:0]    bestIdxReg;
    logic                    bestValidReg;   // low while only NaNs have been seen
    logic [IDX_WIDTH-1:0]    cntReg;
    logic [IDX_WIDTH-1:0]    classIdxReg;
    logic [DATA_WIDTH-1:0]   maxValueReg;

    logic [DATA_WIDTH-1:0]   curElem;
    logic                    curNan;
    logic                    e0Nan;
    logic                    takeCur;
    logic                    lastElem;

    // Unpack the flat input bus into element lanes.
    generate
        for (genvar gi = 0; gi < INPUT_NUM; gi++) begin : g_unpack
            assign elemIn[gi] = inputs[DATA_WIDTH*gi +: DATA_WIDTH];
        end
    endgenerate

    // Map a float bit pattern onto an unsigned key. Comparing the keys gives a
    // total order that matches numeric order for non-NaN values. -0 sorts
    // below +0.
    function automatic logic [DATA_WIDTH-1:0] sortKey(input logic [DATA_WIDTH-1:0] v);
        return v[DATA_WIDTH-1] ? ~v : {1'b1, v[DATA_WIDTH-2:0]};
    endfunction

`ifdef ARGMAX_NAN_CHECK_EN
    function automatic logic isNan(input logic [DATA_WIDTH-1:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    assign curNan = isNan(curElem);
    assign e0Nan  = isNan(elemIn[0]);
`else
    assign curNan = 1'b0;
    assign e0Nan  = 1'b0;
`endif

    assign curElem  = bufferReg[cntReg];
    assign lastElem = (cntReg == LAST_IDX);
    // Replacement requires a strictly greater key, so ties keep the lower
    // index. A non-NaN element always replaces a best that is not yet valid.
    assign takeCur  = !curNan &&
                      (!bestValidReg || (sortKey(curElem) > sortKey(bestReg)));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (in_valid) stateNext = (INPUT_NUM == 1) ? DONE : SCAN;
            SCAN: if (lastElem) stateNext = DONE;
            DONE: if (!in_valid) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy = (stateReg == SCAN);
        done = (stateReg == DONE);
    end

    assign class_idx = classIdxReg;
    assign max_value = maxValueReg;

    // Capture buffer: the whole vector is loaded in one cycle. It needs no
    // reset because it is only read after a capture.
    always_ff @(posedge clk) begin
        if ((stateReg == IDLE) && in_valid && !reset) begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                bufferReg[i] <= elemIn[i];
            end
        end
    end

`ifdef ARGMAX_NAN_CHECK_EN
    logic nanSeenReg;
    logic nanFlagReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            nanSeenReg <= 1'b0;
            nanFlagReg <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: if (in_valid) begin
                    nanSeenReg <= e0Nan;
                    if (INPUT_NUM == 1) nanFlagReg <= e0Nan;
                end
                SCAN: begin
                    nanSeenReg <= nanSeenReg | curNan;
                    if (lastElem) nanFlagReg <= nanSeenReg | curNan;
                end
                DONE: if (!in_valid) nanFlagReg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign nan_flag = nanFlagReg;
`else
    assign nan_flag = 1'b0;
`endif

    // ---------------- scan datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bestReg      <= '0;
            bestIdxReg   <= '0;
            bestValidReg <= 1'b0;
            cntReg       <= '0;
            classIdxReg  <= '0;
            maxValueReg  <= '0;
        end else begin
            case (stateReg)
                IDLE: if (in_valid) begin
                    bestReg      <= elemIn[0];
                    bestIdxReg   <= '0;
                    bestValidReg <= !e0Nan;
                    cntReg       <= IDX_WIDTH'(1);
                    if (INPUT_NUM == 1) begin
                        classIdxReg <= '0;
                        maxValueReg <= e0Nan ? QNAN : elemIn[0];
                    end
                end
                SCAN: begin
                    if (takeCur) begin
                        bestReg      <= curElem;
                        bestIdxReg   <= cntReg;
                        bestValidReg <= 1'b1;
                    end
                    cntReg <= cntReg + 1'b1;
                    // The last element is compared and published on the same
                    // edge, so the result includes it.
                    if (lastElem) begin
                        if (takeCur) begin
                            classIdxReg <= cntReg;
                            maxValueReg <= curElem;
                        end else if (bestValidReg) begin
                            classIdxReg <= bestIdxReg;
                            maxValueReg <= bestReg;
                        end else begin
                            classIdxReg <= '0;
                            maxValueReg <= QNAN;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
